// File: rtl/seq_bw_multiplier.sv
// seq_bw_multiplier: iterative Baugh-Wooley multiplier with runtime
// signed/unsigned selection and valid/ready handshakes on both sides.
// ROWS partial-product rows are summed into a 2*WIDTH-bit accumulator per
// RUN cycle; the finished product is registered on the first DONE cycle.
// Optional feature: define MULT_ACC_EN to add the acc_en input, which seeds
// the accumulator with the previously consumed product (multiply-accumulate).
module seq_bw_multiplier #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic                 signed_mode,
`ifdef MULT_ACC_EN
  input  logic                 acc_en,
`endif
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - ROWS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [CW-1:0]        cnt_p0;
  logic [WIDTH-1:0]     a_p0;
  logic [WIDTH-1:0]     b_p0;
  logic                 sgn_p0;
  logic [2*WIDTH-1:0]   acc_p0;
  logic [2*WIDTH-1:0]   prod_p1;
  logic                 vld_p1;
  logic [2*WIDTH-1:0]   rows_sum;
  logic [2*WIDTH-1:0]   acc_init;

  // Partial-product row k, already shifted into product alignment. In signed
  // mode the row's sign-position bit (or, for the last row, every bit except
  // the sign-position bit) is inverted; the correction constant compensates.
  function automatic logic [2*WIDTH-1:0] pp_row(input int k,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sgn);
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] r;
    a_sh = a >> k;
    r = b & {WIDTH{a_sh[0]}};
    if (sgn) begin
      if (k == WIDTH - 1) r = {r[WIDTH-1], ~r[WIDTH-2:0]};
      else                r = {~r[WIDTH-1], r[WIDTH-2:0]};
    end
    return {{WIDTH{1'b0}}, r} << k;
  endfunction

  // Baugh-Wooley correction: 2^WIDTH + 2^(2*WIDTH-1) for signed, else zero.
  function automatic logic [2*WIDTH-1:0] corr_const(input logic sgn);
    logic [2*WIDTH-1:0] c;
    c = '0;
    c[WIDTH]       = sgn;
    c[2*WIDTH-1]   = sgn;
    return c;
  endfunction

  // Sum of the ROWS rows handled this RUN cycle.
  always_comb begin
    rows_sum = '0;
    for (int r = 0; r < ROWS; r++)
      rows_sum = rows_sum + pp_row(int'(cnt_p0) + r, a_p0, b_p0, sgn_p0);
  end

  // Accumulator seed for a newly accepted operation.
  always_comb begin
`ifdef MULT_ACC_EN
    acc_init = corr_const(signed_mode) + (acc_en ? prod_p1 : '0);
`else
    acc_init = corr_const(signed_mode);
`endif
  end

  // Control FSM with operand capture, row accumulation and result register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt_p0  <= '0;
      a_p0    <= '0;
      b_p0    <= '0;
      sgn_p0  <= 1'b0;
      acc_p0  <= '0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_p0   <= inA;
            b_p0   <= inB;
            sgn_p0 <= signed_mode;
            acc_p0 <= acc_init;
            cnt_p0 <= '0;
            state  <= S_RUN;
          end
        end
        // p0 -> p1: rows accumulate until the last row has been added
        S_RUN: begin
          acc_p0 <= acc_p0 + rows_sum;
          if (cnt_p0 == LAST_C) begin
            cnt_p0 <= '0;
            state  <= S_DONE;
          end else begin
            cnt_p0 <= cnt_p0 + ROWS_C;
          end
        end
        S_DONE: begin
          if (!vld_p1) begin
            prod_p1 <= acc_p0;
            vld_p1  <= 1'b1;
          end else if (out_ready) begin
            vld_p1 <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign out_valid = vld_p1;
  assign product   = prod_p1;

endmodule

// File: tb/tb_seq_bw_multiplier.sv
// Directed bench for seq_bw_multiplier: a ROWS=1 and a ROWS=4 instance share
// clock, reset and operand buses; each has its own handshake signals.
// With MULT_ACC_EN defined the multiply-accumulate sequence is also run.
module tb_seq_bw_multiplier;

  logic        clock;
  logic        reset_n;
  logic [15:0] inA;
  logic [15:0] inB;
  logic        signed_mode;
`ifdef MULT_ACC_EN
  logic        acc_en;
`endif
  logic        in_valid,  in_ready,  busy,  out_valid,  out_ready;
  logic        in_valid4, in_ready4, busy4, out_valid4, out_ready4;
  logic [31:0] product, product4;

  int n_vec = 0;
  int n_err = 0;

  seq_bw_multiplier #(.WIDTH(16), .ROWS(1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .signed_mode(signed_mode),
`ifdef MULT_ACC_EN
    .acc_en(acc_en),
`endif
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  seq_bw_multiplier #(.WIDTH(16), .ROWS(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .inA(inA), .inB(inB), .signed_mode(signed_mode),
`ifdef MULT_ACC_EN
    .acc_en(acc_en),
`endif
    .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready4), .product(product4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid of the selected instance; lat counts edges
  // after the accept edge.
  task automatic wait_done(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? out_valid4 : out_valid) && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic consume(input bit sel, input string tag);
    @(negedge clock);
    if (sel) out_ready4 = 1'b1; else out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready4 = 1'b0;
    out_ready  = 1'b0;
    check({63'd0, sel ? out_valid4 : out_valid}, 64'd0, {tag, "_vld_clr"});
    check({63'd0, sel ? in_ready4 : in_ready}, 64'd1, {tag, "_rdy_back"});
  endtask

  task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp_p, input int exp_lat,
                        input string tag);
    int lat;
    @(negedge clock);
    inA = a; inB = b; signed_mode = s;
    if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
    check({63'd0, sel ? in_ready4 : in_ready}, 64'd1, {tag, "_in_ready"});
    @(posedge clock); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    // scramble the input buses: only captured values may be used
    inA = ~a; inB = 16'h5A5A; signed_mode = ~s;
    check({63'd0, sel ? busy4 : busy}, 64'd1, {tag, "_busy"});
    wait_done(sel, lat);
    check(64'(lat), 64'(exp_lat), {tag, "_latency"});
    check({32'd0, sel ? product4 : product}, {32'd0, exp_p}, {tag, "_product"});
    consume(sel, tag);
  endtask

  initial begin
    int  lat;
    bit  seen;
    reset_n = 1'b0;
    inA = '0; inB = '0; signed_mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
`ifdef MULT_ACC_EN
    acc_en = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check({63'd0, in_ready},  64'd1, "rst_in_ready");
    check({63'd0, busy},      64'd0, "rst_busy");
    check({63'd0, out_valid}, 64'd0, "rst_out_valid");
    check({32'd0, product},   64'd0, "rst_product");
    reset_n = 1'b1;

    // signed and unsigned products, ROWS=1
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 17, "s_m1xm1");
    run_op(0, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 17, "s_minxmin");
    run_op(0, 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 17, "s_maxxmin");
    run_op(0, 16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000, 17, "s_minx1");
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 17, "u_maxxmax");
    run_op(0, 16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 17, "u_mixed");

    // ROWS=4 instance
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 5, "r4_u_maxxmax");
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 5, "r4_s_m1xm1");
    run_op(1, 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 5, "r4_s_maxxmin");

    // backpressure: product held while out_ready is low, new requests ignored
    @(negedge clock);
    inA = 16'd2; inB = 16'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_done(0, lat);
    check(64'(lat), 64'd17, "bp_latency");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = 1'b1; inA = 16'($urandom); inB = 16'($urandom);
      @(posedge clock); #1;
      check({63'd0, out_valid}, 64'd1, "bp_out_valid");
      check({32'd0, product}, 64'd6, "bp_product");
      check({63'd0, in_ready}, 64'd0, "bp_in_ready");
    end
    @(negedge clock);
    inA = 16'd7; inB = 16'd9; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({63'd0, out_valid}, 64'd0, "bp_consumed");
    check({63'd0, in_ready}, 64'd1, "bp_idle_rdy");
    check({63'd0, busy}, 64'd0, "bp_idle_busy");
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({63'd0, busy}, 64'd1, "bp_next_accept");
    wait_done(0, lat);
    check(64'(lat), 64'd17, "bp_next_latency");
    check({32'd0, product}, 64'h3F, "bp_next_product");
    consume(0, "bp_next");

    // asynchronous reset in the middle of RUN
    @(negedge clock);
    inA = 16'hFFFF; inB = 16'hFFFF; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check({63'd0, in_ready},  64'd1, "mid_rst_in_ready");
    check({63'd0, busy},      64'd0, "mid_rst_busy");
    check({63'd0, out_valid}, 64'd0, "mid_rst_out_valid");
    check({32'd0, product},   64'd0, "mid_rst_product");
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    check({63'd0, seen}, 64'd0, "mid_rst_no_valid");
    run_op(0, 16'd3, 16'd5, 1'b0, 32'h0000_000F, 17, "after_rst");

`ifdef MULT_ACC_EN
    acc_en = 1'b0;
    run_op(0, 16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA, 17, "mac_first");
    acc_en = 1'b1;
    run_op(0, 16'h0004, 16'h0002, 1'b1, 32'h0000_0002, 17, "mac_accum");
    acc_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_bw_multiplier.md
Name: seq_bw_multiplier

Overview:
- Parametrised, iterative Baugh-Wooley multiplier. It is the sequential successor of the 16x16 combinational two's-complement array multiplier.
- Accumulates ROWS partial-product rows per clock into a 2*WIDTH-bit register.
- Runtime signed/unsigned mode selection.
- Valid/ready handshake on input and output, so it can sit behind the ALU32 operand registers without a combinational 2W-bit adder chain.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 4.
- ROWS, 1, partial-product rows summed per cycle; must divide WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- inA  input  WIDTH  multiplier operand.
- inB  input  WIDTH  multiplicand operand.
- signed_mode  input  1  1 = two's complement, 0 = unsigned.
- busy  output  1  high while in RUN.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result, modulo 2^(2*WIDTH).

Behaviour:
- Interface: one clock, `clock`; reset is asynchronous and active-low, `reset_n`.
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, product=0, row counter=0, accumulator=0, captured operands=0.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid=1, capture inA, inB and signed_mode. Set the accumulator to the correction constant, clear the row counter and go to RUN.
  - Correction constant: in signed mode, bits WIDTH and 2*WIDTH-1 set. In unsigned mode, 0.
  - RUN: in_ready=0, busy=1. Each cycle add ROWS rows (row index k = counter..counter+ROWS-1) to the accumulator and advance the counter by ROWS. After row WIDTH-1 is added, go to DONE.
  - RUN lasts exactly WIDTH/ROWS cycles.
  - DONE: out_valid=1 and product holds the accumulator. Hold both stable while out_ready=0. On out_ready=1, go to IDLE.
- Row k, unsigned mode: bit j = a_k & b_j, shifted left by k.
- Row k, signed mode, k < WIDTH-1:
  - bits j < WIDTH-1 are a_k & b_j;
  - bit WIDTH-1 is ~(a_k & b_{WIDTH-1});
  - row is shifted left by k.
- Row WIDTH-1, signed mode:
  - bits j < WIDTH-1 are ~(a_{WIDTH-1} & b_j);
  - bit WIDTH-1 is a_{WIDTH-1} & b_{WIDTH-1};
  - row is shifted left by WIDTH-1.
- All additions wrap modulo 2^(2*WIDTH); carry-out is discarded.
- Latency: the in_valid/in_ready handshake at edge N gives out_valid=1 after edge N+WIDTH/ROWS+1.
- in_ready is never 1 while out_valid=1. No new operation is accepted until the product is consumed; a single operation is in flight.
- Operand or mode changes on the inputs during RUN/DONE are ignored; only the captured values are used.
- Reset asserted mid-operation aborts immediately to the reset values; no out_valid is produced for the aborted operation.
- Back-to-back operation: consume in DONE at edge M, IDLE at M, earliest next accept at edge M+1.

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined:
  - Adds input port acc_en (1 bit), captured with the operands.
  - When acc_en=1, the accumulator is initialised to the previous product plus the correction constant instead of the constant alone, giving multiply-accumulate with wrap modulo 2^(2*WIDTH).
  - The previous product is the last consumed product, or 0 after reset.
- Not defined: no acc_en port; every operation starts from the correction constant only.

Test Plan:
- WIDTH=16, ROWS=1, signed: inA=0xFFFF, inB=0xFFFF -> product=0x00000001, out_valid exactly 17 cycles after accept.
- Signed: inA=0x8000, inB=0x8000 -> 0x40000000. Signed: inA=0x7FFF, inB=0x8000 -> 0xC0008000.
- Unsigned: inA=0xFFFF, inB=0xFFFF -> 0xFFFE0001. Repeat with ROWS=4 -> same value, out_valid 5 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> product and out_valid stable, in_ready=0, new in_valid ignored. Release -> next accept on the following edge.
- Reset mid-op: pulse reset_n low at RUN cycle 6 -> all outputs at reset values asynchronously, out_valid never asserted. Next operation 3*5 unsigned -> 0x0000000F.
- MULT_ACC_EN: signed 0xFFFE*0x0003 (acc_en=0) -> 0xFFFFFFFA; then 0x0004*0x0002 (acc_en=1) -> 0x00000002.
